tftp_ack_err_tx: RTL

Transmit-side TFTP control-packet builder, the counterpart of the receive-side opcode/mode decoders. On a start strobe it serialises either an ACK packet (opcode 4 + block number) or an ERROR packet (opcode 5 + error code + fixed ASCII message + NUL) as a byte stream with valid/ready handshake. The stream feeds the UDP/IP/Ethernet tx framer, which adds all headers.

---
 rtl/tftp_pkg.sv | 66 ++++++
 rtl/tftp_err_msg_rom.sv | 45 ++++
 rtl/tftp_ack_err_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tftp_pkg.sv
// -----------------------------------------------------------------------------
// tftp_pkg
// Shared TFTP definitions for the rx decoders and the tx packet builder:
//   - opcode constants (RRQ/WRQ/DATA/ACK/ERROR)
//   - standard error-code constants
//   - ASCII constants (NUL terminator, transfer-mode strings)
//   - error-message texts and a helper that extracts one character
//   - state encoding of the ACK/ERROR transmit FSM
// -----------------------------------------------------------------------------
package tftp_pkg;

  // Opcodes
  localparam logic [15:0] OP_RRQ   = 16'd1;
  localparam logic [15:0] OP_WRQ   = 16'd2;
  localparam logic [15:0] OP_DATA  = 16'd3;
  localparam logic [15:0] OP_ACK   = 16'd4;
  localparam logic [15:0] OP_ERROR = 16'd5;

  // Error codes
  localparam logic [15:0] ERR_NOT_DEFINED      = 16'd0;
  localparam logic [15:0] ERR_FILE_NOT_FOUND   = 16'd1;
  localparam logic [15:0] ERR_ACCESS_VIOLATION = 16'd2;
  localparam logic [15:0] ERR_DISK_FULL        = 16'd3;
  localparam logic [15:0] ERR_ILLEGAL_OP       = 16'd4;

  // ASCII constants
  localparam logic [7:0]    ASCII_NUL     = 8'h00;
  localparam logic [39:0]   MODE_OCTET    = "octet";
  localparam logic [63:0]   MODE_NETASCII = "netascii";

  // Error message texts, right-aligned in a fixed-width container so every
  // message shares one type; the real length travels alongside.
  localparam int MSG_MAX_LEN = 22;
  localparam int MSG_W       = 8 * MSG_MAX_LEN;

  localparam logic [MSG_W-1:0] MSG_NOT_DEFINED      = MSG_W'("Not defined");
  localparam logic [MSG_W-1:0] MSG_FILE_NOT_FOUND   = MSG_W'("File not found");
  localparam logic [MSG_W-1:0] MSG_ACCESS_VIOLATION = MSG_W'("Access violation");
  localparam logic [MSG_W-1:0] MSG_ILLEGAL_OP       = MSG_W'("Illegal TFTP operation");

  // Transmit FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC_HI,
    ST_OPC_LO,
    ST_FLD_HI,
    ST_FLD_LO,
    ST_MSG,
    ST_NUL,
    ST_DONE
  } tx_state_e;

  // Character idx (0 = first character) of a right-aligned text of length
  // len. The first character sits in the most significant occupied byte.
  function automatic logic [7:0] msg_char(input logic [MSG_W-1:0] text,
                                          input logic [4:0]       len,
                                          input logic [4:0]       idx);
    logic [4:0] pos;
    msg_char = ASCII_NUL;
    if (idx < len) begin
      pos      = len - 5'd1 - idx;
      msg_char = text[{pos, 3'b000} +: 8];
    end
  endfunction

endpackage

// File: rtl/tftp_err_msg_rom.sv
// -----------------------------------------------------------------------------
// tftp_err_msg_rom
// Purely combinational error-message table.
//   err_code [15:0] in  : TFTP error code selecting the message
//   idx      [4:0]  in  : character index within the message
//   char     [7:0]  out : ASCII character at idx (0 beyond the end)
//   msg_len  [4:0]  out : message length in characters, no terminator
// Unknown codes map to the "Not defined" text.
// -----------------------------------------------------------------------------
module tftp_err_msg_rom
  import tftp_pkg::*;
(
  input  logic [15:0] err_code,
  input  logic [4:0]  idx,
  output logic [7:0]  char,
  output logic [4:0]  msg_len
);

  logic [MSG_W-1:0] text;

  always_comb begin
    text    = MSG_NOT_DEFINED;
    msg_len = 5'd11;
    case (err_code)
      ERR_FILE_NOT_FOUND: begin
        text    = MSG_FILE_NOT_FOUND;
        msg_len = 5'd14;
      end
      ERR_ACCESS_VIOLATION: begin
        text    = MSG_ACCESS_VIOLATION;
        msg_len = 5'd16;
      end
      ERR_ILLEGAL_OP: begin
        text    = MSG_ILLEGAL_OP;
        msg_len = 5'd22;
      end
      default: begin
        text    = MSG_NOT_DEFINED;
        msg_len = 5'd11;
      end
    endcase
    char = msg_char(text, msg_len, idx);
  end

endmodule

// File: rtl/tftp_ack_err_tx.sv
// -----------------------------------------------------------------------------
// tftp_ack_err_tx
// Serialises a TFTP ACK (opcode + block number) or ERROR packet (opcode +
// error code + message + NUL) as a byte stream with valid/ready handshake.
//   clk, reset          : clock, synchronous active-high reset
//   start               : request, honoured only while idle
//   pkt_type            : 0 = ACK, 1 = ERROR (sampled with start)
//   block_num, err_code : packet fields (sampled with start)
//   tx_data/valid/last  : byte stream out, tx_ready : downstream accept
//   busy                : packet in progress
//   done                : one-cycle pulse after the last byte is accepted
//   tx_abort            : one-cycle pulse when the stall limit is hit
// All outputs are registered: the next-state decode also decides the next
// output values, so each byte appears one cycle after its state is chosen.
// -----------------------------------------------------------------------------
module tftp_ack_err_tx
  import tftp_pkg::*;
#(
  parameter logic [15:0] ACK_OPCODE  = OP_ACK,
  parameter logic [15:0] ERR_OPCODE  = OP_ERROR,
  parameter int          STALL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pkt_type,
  input  logic [15:0] block_num,
  input  logic [15:0] err_code,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        tx_abort
);

  // A limit of 0 disables the check; keep the counter at least one bit wide.
  localparam int STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  tx_state_e          state_q, state_d;
  logic               pkt_q, pkt_d;
  logic [15:0]        blk_q, blk_d;
  logic [15:0]        err_q, err_d;
  logic [4:0]         idx_q, idx_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;

  logic        accept;
  logic [7:0]  rom_char;
  logic [4:0]  msg_len;
  logic [15:0] opcode;
  logic [15:0] field;

  assign accept = tx_valid_q & tx_ready;

  // err_q is stable for the whole packet, so msg_len depends only on
  // registered state and can safely steer idx_d.
  tftp_err_msg_rom u_rom (
    .err_code (err_q),
    .idx      (idx_d),
    .char     (rom_char),
    .msg_len  (msg_len)
  );

  // Next-state decode
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    blk_d   = blk_q;
    err_d   = err_q;
    idx_d   = idx_q;
    stall_d = stall_q;
    abort_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (start) begin
          pkt_d   = pkt_type;
          blk_d   = block_num;
          err_d   = err_code;
          state_d = ST_OPC_HI;
        end
      end
      ST_OPC_HI: if (accept) state_d = ST_OPC_LO;
      ST_OPC_LO: if (accept) state_d = ST_FLD_HI;
      ST_FLD_HI: if (accept) state_d = ST_FLD_LO;
      ST_FLD_LO: begin
        if (accept) begin
          if (pkt_q) begin
            state_d = ST_MSG;
            idx_d   = 5'd0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MSG: begin
        if (accept) begin
          if (idx_q == msg_len - 5'd1) state_d = ST_NUL;
          else                         idx_d   = idx_q + 5'd1;
        end
      end
      ST_NUL:  if (accept) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Stall supervision overrides the normal progression.
    if (tx_valid_q) begin
      if (tx_ready) begin
        stall_d = '0;
      end else if (STALL_LIMIT != 0) begin
        if (stall_q + STALL_W'(1) == STALL_MAX) begin
          state_d = ST_IDLE;
          stall_d = '0;
          abort_d = 1'b1;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
    end
  end

  // Output decode from the next state and next latched fields
  always_comb begin
    opcode     = pkt_d ? ERR_OPCODE : ACK_OPCODE;
    field      = pkt_d ? err_d : blk_d;
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b0;
    tx_last_d  = 1'b0;
    done_d     = 1'b0;

    case (state_d)
      ST_OPC_HI: begin tx_valid_d = 1'b1; tx_data_d = opcode[15:8]; end
      ST_OPC_LO: begin tx_valid_d = 1'b1; tx_data_d = opcode[7:0];  end
      ST_FLD_HI: begin tx_valid_d = 1'b1; tx_data_d = field[15:8];  end
      ST_FLD_LO: begin
        tx_valid_d = 1'b1;
        tx_data_d  = field[7:0];
        tx_last_d  = ~pkt_d;
      end
      ST_MSG:    begin tx_valid_d = 1'b1; tx_data_d = rom_char;     end
      ST_NUL: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ASCII_NUL;
        tx_last_d  = 1'b1;
      end
      ST_DONE:   done_d = 1'b1;
      default:   ;
    endcase

    busy_d = tx_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pkt_q      <= 1'b0;
      blk_q      <= '0;
      err_q      <= '0;
      idx_q      <= '0;
      stall_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      blk_q      <= blk_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      stall_q    <= stall_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_abort = abort_q;

endmodule
